// File: rtl/prog_loader_mem.sv
// 16x8 writable program memory with a valid/ready byte-stream loader that holds the CPU in reset while loading.
// Optional build macro PROG_LOADER_MEM_BOOT_IMAGE_EN: reset preloads a small boot program and starts in RUN.
module prog_loader_mem (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] address,
  output logic [7:0] instr,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic [4:0] ld_count,
  output logic       done,
  output logic       cpu_n_reset
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t     state_reg;
  logic [3:0] wr_ptr_reg;
  logic [4:0] ld_count_reg;
  logic       done_reg;
  logic       ld_ready_reg;
  logic       cpu_n_reset_reg;
  logic       accept;
  logic [7:0] mem_word [16];

  // A restart request in the same cycle as a byte takes priority and drops the byte.
  assign accept = (state_reg == LOAD) && ld_valid && !ld_start;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef PROG_LOADER_MEM_BOOT_IMAGE_EN
      state_reg       <= RUN;
      cpu_n_reset_reg <= 1'b1;
`else
      state_reg       <= IDLE;
      cpu_n_reset_reg <= 1'b0;
`endif
      wr_ptr_reg      <= 4'd0;
      ld_count_reg    <= 5'd0;
      done_reg        <= 1'b0;
      ld_ready_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ld_start) begin
            state_reg    <= LOAD;
            ld_ready_reg <= 1'b1;
            wr_ptr_reg   <= 4'd0;
            ld_count_reg <= 5'd0;
          end
        end
        LOAD: begin
          if (ld_start) begin
            wr_ptr_reg   <= 4'd0;
            ld_count_reg <= 5'd0;
          end else if (ld_valid) begin
            ld_count_reg <= ld_count_reg + 5'd1;
            if (wr_ptr_reg == 4'd15) begin
              // Pointer parks at the last word rather than wrapping.
              state_reg       <= RUN;
              done_reg        <= 1'b1;
              ld_ready_reg    <= 1'b0;
              cpu_n_reset_reg <= 1'b1;
            end else begin
              wr_ptr_reg <= wr_ptr_reg + 4'd1;
            end
          end
        end
        RUN: begin
          if (ld_start) begin
            state_reg       <= LOAD;
            ld_ready_reg    <= 1'b1;
            cpu_n_reset_reg <= 1'b0;
            wr_ptr_reg      <= 4'd0;
            ld_count_reg    <= 5'd0;
          end
        end
        default: begin
          state_reg       <= IDLE;
          ld_ready_reg    <= 1'b0;
          cpu_n_reset_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
`ifdef PROG_LOADER_MEM_BOOT_IMAGE_EN
      localparam logic [7:0] RESET_WORD = (gi == 0) ? 8'hB1 :
                                          (gi == 1) ? 8'hB2 :
                                          (gi == 2) ? 8'hB4 :
                                          (gi == 3) ? 8'hB8 :
                                          (gi == 4) ? 8'hF0 : 8'h00;
`else
      localparam logic [7:0] RESET_WORD = 8'h00;
`endif
      logic [7:0] word_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg <= RESET_WORD;
        end else if (accept && (wr_ptr_reg == 4'(gi))) begin
          word_reg <= ld_data;
        end
      end

      assign mem_word[gi] = word_reg;
    end
  endgenerate

  // The core only ever sees real instructions while it is out of reset.
  assign instr       = (state_reg == RUN) ? mem_word[address] : 8'h00;
  assign ld_ready    = ld_ready_reg;
  assign ld_count    = ld_count_reg;
  assign done        = done_reg;
  assign cpu_n_reset = cpu_n_reset_reg;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Self-checking bench for prog_loader_mem: accepted writes go into a scoreboard queue and are read back in RUN.
module tb_prog_loader_mem;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] address = 4'd0;
  logic [7:0] instr;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready;
  logic [4:0] ld_count;
  logic       done;
  logic       cpu_n_reset;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sbq[$];
  int  tests = 0;
  int  fails = 0;
  int  tb_ptr = 0;

  prog_loader_mem dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .instr       (instr),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_count    (ld_count),
    .done        (done),
    .cpu_n_reset (cpu_n_reset)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("[TB] ok %s = %b", name, act);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%02h", name, act);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    tick();
    reset = 1'b0;
    sbq.delete();
    tb_ptr = 0;
  endtask

  task automatic start_load;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    sbq.delete();
    tb_ptr = 0;
    check_bit("start.ld_ready", ld_ready, 1'b1);
    check_bit("start.cpu_n_reset", cpu_n_reset, 1'b0);
    check_val("start.ld_count", 8'(ld_count), 8'd0);
    check_val("start.instr", instr, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
    sbq.push_back('{addr: 4'(tb_ptr), data: d});
    tb_ptr++;
    check_val($sformatf("accept%0d.ld_count", tb_ptr), 8'(ld_count), 8'(tb_ptr));
    if (tb_ptr < 16) begin
      check_bit($sformatf("accept%0d.done", tb_ptr), done, 1'b0);
    end else begin
      check_bit("last.done", done, 1'b1);
      check_bit("last.cpu_n_reset", cpu_n_reset, 1'b1);
      check_bit("last.ld_ready", ld_ready, 1'b0);
    end
  endtask

  task automatic finish_load;
    tick();
    check_bit("after.done", done, 1'b0);
    check_val("after.ld_count", 8'(ld_count), 8'd16);
  endtask

  task automatic drain_scoreboard(input string tag);
    wr_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      address = e.addr;
      #1;
      check_val($sformatf("%s.mem[%0d]", tag, e.addr), instr, e.data);
    end
  endtask

  task automatic test_reset;
    do_reset();
    check_bit("reset.ld_ready", ld_ready, 1'b0);
    check_bit("reset.done", done, 1'b0);
    check_val("reset.ld_count", 8'(ld_count), 8'd0);
`ifdef PROG_LOADER_MEM_BOOT_IMAGE_EN
    check_bit("reset.cpu_n_reset", cpu_n_reset, 1'b1);
    address = 4'd3;
    #1;
    check_val("boot.mem[3]", instr, 8'hB8);
    address = 4'd4;
    #1;
    check_val("boot.mem[4]", instr, 8'hF0);
`else
    check_bit("reset.cpu_n_reset", cpu_n_reset, 1'b0);
    address = 4'd0;
    #1;
    check_val("reset.instr", instr, 8'h00);
    // Stray valid in IDLE must be ignored.
    ld_valid = 1'b1;
    ld_data  = 8'h77;
    tick();
    ld_valid = 1'b0;
    check_bit("idle_valid.ld_ready", ld_ready, 1'b0);
    check_val("idle_valid.ld_count", 8'(ld_count), 8'd0);
`endif
  endtask

  task automatic test_back_to_back;
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i));
    finish_load();
    address = 4'd5;
    #1;
    check_val("b2b.addr5", instr, 8'h35);
    drain_scoreboard("b2b");
  endtask

  task automatic test_run_restart;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'hEE;
      tick();
    end
    ld_valid = 1'b0;
    check_val("run_valid.ld_count", 8'(ld_count), 8'd16);
    address = 4'd0;
    #1;
    check_val("run_valid.mem[0]", instr, 8'h30);
    address = 4'd1;
    #1;
    check_val("run_valid.mem[1]", instr, 8'h31);
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i));
    finish_load();
    drain_scoreboard("reload");
  endtask

  task automatic test_gapped;
    int cycles;
    start_load();
    cycles = 0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h30 + 8'(i));
      cycles++;
      if (i < 15) begin
        tick();
        cycles++;
      end
    end
    tests++;
    if (cycles != 31) begin
      fails++;
      $display("[TB] FAIL gapped.cycles: got %0d expected 31", cycles);
    end else begin
      $display("[TB] ok gapped.cycles = %0d", cycles);
    end
    finish_load();
    drain_scoreboard("gapped");
  endtask

  task automatic test_start_collision;
    start_load();
    for (int i = 0; i < 7; i++) send_byte(8'h60 + 8'(i));
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hAA;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    sbq.delete();
    tb_ptr = 0;
    check_val("collide.ld_count", 8'(ld_count), 8'd0);
    check_bit("collide.ld_ready", ld_ready, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'h70 + 8'(i));
    finish_load();
    drain_scoreboard("collide");
  endtask

  task automatic test_reset_mid_load;
    start_load();
    for (int i = 0; i < 9; i++) send_byte(8'h80 + 8'(i));
    do_reset();
    check_bit("midrst.ld_ready", ld_ready, 1'b0);
    check_val("midrst.ld_count", 8'(ld_count), 8'd0);
`ifdef PROG_LOADER_MEM_BOOT_IMAGE_EN
    check_bit("midrst.cpu_n_reset", cpu_n_reset, 1'b1);
    address = 4'd0;
    #1;
    check_val("midrst.instr", instr, 8'hB1);
`else
    check_bit("midrst.cpu_n_reset", cpu_n_reset, 1'b0);
    address = 4'd0;
    #1;
    check_val("midrst.instr", instr, 8'h00);
`endif
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'h00);
    finish_load();
    drain_scoreboard("zeros");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_run_restart();
    test_gapped();
    test_start_collision();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
